// File: rtl/ddr_cdc_pkg.sv
// Shared helpers for the addr_ctrl clock-domain-crossing blocks:
// Gray/binary conversion, counter sizing and common defaults.
package ddr_cdc_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned GRAY_MAX_WIDTH      = 64;

  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

  // Zero-extended inputs decode correctly because leading zeros add nothing to the xor.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b = g;
    for (int unsigned s = 1; s < GRAY_MAX_WIDTH; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-stage flop pipeline used to bring a signal into the clk domain.
module sync_chain
  import ddr_cdc_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/bus_stable_sync.sv
// Multi-bit CDC capture for slowly changing buses: the synchronised sample must
// hold for STABLE_CYCLES consecutive compares before it is loaded to data_out.
module bus_stable_sync
  import ddr_cdc_pkg::*;
#(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int unsigned      STABLE_CYCLES = 2,
  parameter bit               GRAY_IN       = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             update,
  output logic             stable
);

  localparam int unsigned     CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] samp_d;
  logic [WIDTH-1:0] cap;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             eq;
  logic             load;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_in),
    .q   (samp)
  );

  // Saturation at CNT_MAX is what limits each stable plateau to a single load.
  always_comb begin
    eq       = (samp == samp_d);
    cnt_next = '0;
    if (eq) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end
    load = eq && (cnt == CNT_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_d <= RESET_VALUE;
      cap    <= RESET_VALUE;
      cnt    <= '0;
      update <= 1'b0;
      stable <= 1'b0;
    end else begin
      samp_d <= samp;
      cnt    <= cnt_next;
      stable <= (cnt_next == CNT_MAX);
      update <= 1'b0;
      if (load) begin
        cap    <= samp;
        update <= (samp != cap);
      end
    end
  end

  generate
    if (GRAY_IN) begin : g_gray
      assign data_out = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(cap)));
    end else begin : g_bin
      assign data_out = cap;
    end
  endgenerate

endmodule
